// File: rtl/decoder_if.sv
// decoder_if: channel-index request bus and one-hot select response bus for the decoder
interface decoder_if #(
  parameter int NSLOT = 1,
  parameter int OUT_CH = 64,
  parameter int BIT_OUT_CH = $clog2(OUT_CH)
);
  logic in_valid;
  logic [NSLOT*BIT_OUT_CH-1:0] WHICH_FILTER;
  logic [OUT_CH*NSLOT-1:0] demux;
  logic out_valid;
  modport master (output in_valid, WHICH_FILTER, input demux, out_valid);
  modport slave (input in_valid, WHICH_FILTER, output demux, out_valid);
endinterface

// File: rtl/decoder.sv
// decoder: registered per-slot binary-to-one-hot channel select, one decode per cycle
module decoder #(
  parameter int NUM_MACRO = 1,
  parameter int OUT_CH = 64,
  parameter int MAX_NUM_FILTER = 1
) (
  input logic clk,
  input logic rst_n,
  decoder_if.slave bus
);
  localparam int BIT_OUT_CH = $clog2(OUT_CH);
  localparam int NSLOT = NUM_MACRO*MAX_NUM_FILTER;
  logic [OUT_CH*NSLOT-1:0] dec;
  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    assign dec[s*OUT_CH +: OUT_CH] = {{(OUT_CH-1){1'b0}}, 1'b1} << bus.WHICH_FILTER[s*BIT_OUT_CH +: BIT_OUT_CH];
  end
  // Idle edges clear the selects so demux is zero whenever out_valid is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.demux <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.demux <= bus.in_valid ? dec : '0;
      bus.out_valid <= bus.in_valid;
    end
  end
endmodule

// File: tb/tb_decoder.sv
// tb_decoder: scoreboard bench for a default decoder and a 2x2-slot, 8-channel decoder
module tb_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [64:0] q1[$];
  logic [32:0] q2[$];

  always #5 clk = ~clk;

  decoder_if #(.NSLOT(1), .OUT_CH(64)) b1();
  decoder_if #(.NSLOT(4), .OUT_CH(8)) b2();

  decoder u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  decoder #(.NUM_MACRO(2), .OUT_CH(8), .MAX_NUM_FILTER(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  function automatic logic [63:0] model1(input logic [5:0] w);
    logic [63:0] r = '0;
    for (int k = 0; k < 64; k++) if (w == 6'(k)) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] model2(input logic [11:0] w);
    logic [31:0] r = '0;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 8; k++) if (w[s*3 +: 3] == 3'(k)) r[s*8+k] = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic one_hot2(input string tag);
    for (int s = 0; s < 4; s++) check(tag, 65'($countones(b2.demux[s*8 +: 8])), 65'd1);
  endtask

  task automatic step(input logic v1, input logic [5:0] w1, input logic v2, input logic [11:0] w2, input string tag);
    b1.in_valid = v1;
    b1.WHICH_FILTER = w1;
    b2.in_valid = v2;
    b2.WHICH_FILTER = w2;
    q1.push_back({v1, v1 ? model1(w1) : 64'h0});
    q2.push_back({v2, v2 ? model2(w2) : 32'h0});
    @(posedge clk);
    #1;
    if (q1.size() == 0 || q2.size() == 0) check({tag, "_sb_empty"}, 65'd0, 65'd1);
    else begin
      check({tag, "_d64"}, {b1.out_valid, b1.demux}, q1.pop_front());
      check({tag, "_d8x4"}, 65'({b2.out_valid, b2.demux}), 65'(q2.pop_front()));
      if (b1.out_valid) check({tag, "_1hot64"}, 65'($countones(b1.demux)), 65'd1);
      if (b2.out_valid) one_hot2({tag, "_1hot8"});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.in_valid = 1'b0;
    b1.WHICH_FILTER = '0;
    b2.in_valid = 1'b0;
    b2.WHICH_FILTER = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_d64", {b1.out_valid, b1.demux}, 65'h0);
    check("rst_async_d8x4", 65'({b2.out_valid, b2.demux}), 65'h0);
    for (int i = 0; i < 6; i++) begin
      b1.in_valid = 1'(i);
      b1.WHICH_FILTER = 6'($urandom);
      b2.in_valid = 1'(i);
      b2.WHICH_FILTER = 12'($urandom);
      @(posedge clk);
      #1;
      check("rst_hold_d64", {b1.out_valid, b1.demux}, 65'h0);
      check("rst_hold_d8x4", 65'({b2.out_valid, b2.demux}), 65'h0);
    end
    rst_n = 1'b1;
    step(1'b1, 6'd5, 1'b0, 12'h0, "single5");
    check("single5_lit", {b1.out_valid, b1.demux}, {1'b1, 64'h20});
    step(1'b0, 6'd9, 1'b0, 12'h0, "single5_after");
    check("single5_after_lit", {b1.out_valid, b1.demux}, 65'h0);
    step(1'b1, 6'd0, 1'b0, 12'h0, "idx0");
    check("idx0_lit", {b1.out_valid, b1.demux}, {1'b1, 64'h1});
    step(1'b1, 6'd63, 1'b0, 12'h0, "idx63");
    check("idx63_lit", {b1.out_valid, b1.demux}, {1'b1, 64'h8000_0000_0000_0000});
    step(1'b0, 6'd0, 1'b0, 12'h0, "idle");
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 6'(k), 1'b0, 12'h0, "b2b");
      check("b2b_lit", {b1.out_valid, b1.demux}, {1'b1, 64'h1 << k});
    end
    step(1'b0, 6'd0, 1'b1, {3'd7, 3'd0, 3'd3, 3'd3}, "multi");
    check("multi_lit", 65'({b2.out_valid, b2.demux}), 65'({1'b1, 32'h80_01_08_08}));
    step(1'b0, 6'd0, 1'b0, 12'hfff, "multi_after");
    for (int i = 0; i < 1200; i++) begin
      if (i == 600) begin
        step(1'b1, 6'd17, 1'b1, 12'h5a5, "pre_rst");
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_d64", {b1.out_valid, b1.demux}, 65'h0);
        check("mid_rst_d8x4", 65'({b2.out_valid, b2.demux}), 65'h0);
        q1.delete();
        q2.delete();
        #1 rst_n = 1'b1;
        step(1'b1, 6'd42, 1'b1, 12'h123, "post_rst");
      end
      step(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 1)), 12'($urandom), "rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decoder.md
DECODER -- requirements
Module: decoder

Interface
REQ-001 Parameter NUM_MACRO, default 1: number of macros served.
REQ-002 Parameter OUT_CH, default 64: output channels per filter slot; power of two, at least 2.
REQ-003 Parameter MAX_NUM_FILTER, default 1: filter slots per macro.
REQ-004 Derived localparam BIT_OUT_CH = clog2(OUT_CH), default 6; NSLOT = NUM_MACRO*MAX_NUM_FILTER.
REQ-005 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  WHICH_FILTER is valid this cycle.
REQ-009 WHICH_FILTER  input  NSLOT*BIT_OUT_CH  packed channel indices, one BIT_OUT_CH field per slot.
REQ-010 demux  output  OUT_CH*NSLOT  packed one-hot select vectors, one OUT_CH field per slot.
REQ-011 out_valid  output  1  demux is valid this cycle.

Function
REQ-012 Slot numbering: s = m*MAX_NUM_FILTER + f, with macro m in 0..NUM_MACRO-1 and filter f in 0..MAX_NUM_FILTER-1.
REQ-013 Slot s index field is WHICH_FILTER[s*BIT_OUT_CH +: BIT_OUT_CH], unsigned.
REQ-014 Slot s output field is demux[s*OUT_CH +: OUT_CH].
REQ-015 Decode: for index i, the slot field has bit i = 1 and all other bits = 0 (binary to one-hot).
REQ-016 Every index value 0..OUT_CH-1 is legal; there is no out-of-range case, because BIT_OUT_CH bits span exactly OUT_CH values.
REQ-017 Slots decode independently; two slots may carry the same index.
REQ-018 Latency is 1 cycle: a rising edge with in_valid=1 registers the decode; demux and out_valid are valid from that edge until the next edge.
REQ-019 out_valid is a register equal to in_valid delayed by one cycle.
REQ-020 A rising edge with in_valid=0 sets all demux bits to 0; demux is all-zero whenever out_valid=0.
REQ-021 Back-to-back in_valid is supported at one decode per cycle, with no bubbles and no stall or ready signal.
REQ-022 WHICH_FILTER is sampled only on edges where in_valid=1; its value on other cycles is ignored.
REQ-023 Both outputs are driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-024 rst_n=0 immediately forces demux to all-zero and out_valid to 0, regardless of clk.
REQ-025 Reset asserted mid-stream discards the pending output.
REQ-026 After rst_n rises, the first rising edge with in_valid=1 produces valid output on the following cycle.
REQ-027 No other state exists besides the demux and out_valid registers.

Verification
REQ-028 Reset check: rst_n=0 with in_valid=1 toggling -> demux=0 and out_valid=0 throughout reset.
REQ-029 Single decode (defaults): in_valid=1 with WHICH_FILTER=6'd5 for one cycle -> next cycle out_valid=1 and demux=64'h20; the cycle after, out_valid=0 and demux=0.
REQ-030 Boundary indices (defaults): WHICH_FILTER=0 gives demux=64'h1; WHICH_FILTER=63 gives demux=64'h8000_0000_0000_0000.
REQ-031 Back-to-back (defaults): indices 0..63 on 64 consecutive cycles -> 64 consecutive out_valid=1 cycles, with demux=1<<k on output cycle k.
REQ-032 Multi-slot (NUM_MACRO=2, MAX_NUM_FILTER=2, OUT_CH=8): WHICH_FILTER={3'd7,3'd0,3'd3,3'd3} -> demux=32'h80_01_08_08 one cycle later.
REQ-033 Randomized: at least 1000 cycles of random in_valid and WHICH_FILTER with a random async reset pulse mid-run -> every cycle, each slot field equals 1<<index when out_valid=1 and 0 otherwise, and each field has exactly one bit set while valid.
